store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 164 ++++++++++++++++
 tb/tb_store_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order store queue in front of one synchronous RAM port.
//            Loads share the port and preempt the drain unless the queue is
//            full. Optional store-to-load forwarding: define STORE_FWD_EN.
// Revision : 1.0  initial release
// ============================================================================
module store_buffer #(
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_rsp_valid,
    output logic [DW-1:0]            ld_rsp_data,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_wdata,
    input  logic [DW-1:0]            ram_rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [AW-1:0]      r_addr [DEPTH];
    logic [DW-1:0]      r_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ld_rsp_valid;

    logic               w_full;
    logic               w_empty;
    logic               w_hazard;
    logic [c_PTR_W-1:0] w_idx;
    logic               w_ld_rd;
    logic               w_ld_acc;
    logic               w_drain;
    logic               w_enq;

`ifdef STORE_FWD_EN
    logic [DW-1:0]      w_fwd_data;
    logic               r_fwd_hit;
    logic [DW-1:0]      r_fwd_data;
`endif

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Scan pending entries oldest to youngest so the last hit is the youngest.
    always_comb begin
        w_hazard = 1'b0;
        w_idx    = '0;
`ifdef STORE_FWD_EN
        w_fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && (r_addr[w_idx] == ld_addr)) begin
                w_hazard = 1'b1;
`ifdef STORE_FWD_EN
                w_fwd_data = r_data[w_idx];
`endif
            end
        end
    end

    // A RAM read happens only for a non-hazard load while not full.
    assign w_ld_rd  = ld_valid && !w_full && !w_hazard;
`ifdef STORE_FWD_EN
    assign ld_ready = !w_full;
`else
    assign ld_ready = !w_full && !w_hazard;
`endif
    assign w_ld_acc = ld_valid && ld_ready;
    assign w_drain  = !w_empty && !w_ld_rd;
    assign w_enq    = st_valid && !w_full;

    assign st_ready = !w_full;
    assign empty    = w_empty;
    assign count    = r_count;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_drain) begin
            ram_we    = 1'b1;
            ram_addr  = r_addr[r_rd_ptr];
            ram_wdata = r_data[r_rd_ptr];
        end else if (w_ld_rd) begin
            ram_addr  = ld_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_drain) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_drain) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_rsp_valid <= 1'b0;
        end else begin
            r_ld_rsp_valid <= w_ld_acc;
        end
    end

    assign ld_rsp_valid = r_ld_rsp_valid;

`ifdef STORE_FWD_EN
    // Forwarded data is captured at accept; the matching entry may drain meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_hit <= w_ld_acc && w_hazard;
            if (w_ld_acc && w_hazard) begin
                r_fwd_data <= w_fwd_data;
            end
        end
    end

    assign ld_rsp_data = r_fwd_hit ? r_fwd_data : ram_rdata;
`else
    assign ld_rsp_data = ram_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Directed scoreboard bench for store_buffer with a read-old-data
//            RAM model; honours STORE_FWD_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_store_buffer;

    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           st_valid;
    logic           st_ready;
    logic [AW-1:0]  st_addr;
    logic [DW-1:0]  st_data;
    logic           ld_valid;
    logic           ld_ready;
    logic [AW-1:0]  ld_addr;
    logic           ld_rsp_valid;
    logic [DW-1:0]  ld_rsp_data;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  ram_rdata;
    logic           empty;
    logic [2:0]     count;

    logic           preload;
    logic [DW-1:0]  mem [0:(1<<AW)-1];
    logic [DW-1:0]  ld_exp;
    logic [DW-1:0]  ld_q [$];
    logic [AW+DW-1:0] wr_q [$];
    int             n_cmp = 0;
    int             n_bad = 0;

    always #5 clk = ~clk;

    store_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .empty(empty), .count(count)
    );

    // Synchronous RAM, one-cycle read latency, returns pre-write data.
    always @(posedge clk) begin
        if (preload) begin
            mem[15'h3456] <= 8'h56;
            mem[15'h0100] <= 8'hA5;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: pops expectations whenever the DUT presents a response or a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (ld_rsp_valid) begin
                if (ld_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ld_rsp_unexpected: got data %0h, required no response", ld_rsp_data);
                end else begin
                    chk("ld_rsp_data", 32'(ld_rsp_data), 32'(ld_q.pop_front()));
                end
            end
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ram_write_unexpected: got %0h/%0h, required no write", ram_addr, ram_wdata);
                end else begin
                    chk("ram_write", 32'({ram_addr, ram_wdata}), 32'(wr_q.pop_front()));
                end
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        if (st_valid && st_ready) wr_q.push_back({st_addr, st_data});
        if (ld_valid && ld_ready) ld_q.push_back(ld_exp);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Current cycle already sampled; hold the load until accepted.
    task automatic finish_load();
        int n = 0;
        while (!ld_ready && n < 8) begin
            advance();
            sample();
            n++;
        end
        chk("ld_accept_bound", 32'(ld_ready), 32'd1);
        advance();
        ld_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        sample();
        while (!empty && n < 12) begin
            advance();
            sample();
            n++;
        end
        chk("drain_bound", 32'(empty), 32'd1);
        advance();
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; preload = 1'b0;

        // Reset state
        sample();
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ld_rsp_valid", 32'(ld_rsp_valid), 32'd0);
        advance();

        // Drain order
        st_valid = 1'b1; st_addr = 15'h1234; st_data = 8'h56;
        sample(); advance();
        st_addr = 15'h5678; st_data = 8'h9A;
        sample();
        chk("drain1_we", 32'(ram_we), 32'd1);
        chk("drain1_addr", 32'(ram_addr), 32'h1234);
        chk("drain1_count", 32'(count), 32'd1);
        advance();
        st_valid = 1'b0;
        sample();
        chk("drain2_addr", 32'(ram_addr), 32'h5678);
        advance();
        sample();
        chk("drain_done_empty", 32'(empty), 32'd1);
        chk("drain_done_we", 32'(ram_we), 32'd0);
        advance();

        // Load priority over drain
        st_valid = 1'b1; st_addr = 15'h5678; st_data = 8'h77;
        sample(); advance();
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 15'h3456; ld_exp = 8'h56;
        sample();
        chk("prio_ld_ready", 32'(ld_ready), 32'd1);
        chk("prio_no_drain", 32'(ram_we), 32'd0);
        chk("prio_ram_addr", 32'(ram_addr), 32'h3456);
        advance();
        ld_valid = 1'b0;
        sample();
        chk("prio_rsp_valid", 32'(ld_rsp_valid), 32'd1);
        chk("prio_drain_after", 32'(ram_we), 32'd1);
        advance();
        wait_empty();

        // Hazard on a single pending entry
        st_valid = 1'b1; st_addr = 15'h5678; st_data = 8'h03;
        sample(); advance();
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 15'h5678; ld_exp = 8'h03;
        sample();
`ifdef STORE_FWD_EN
        chk("haz1_ld_ready", 32'(ld_ready), 32'd1);
`else
        chk("haz1_ld_ready", 32'(ld_ready), 32'd0);
`endif
        chk("haz1_drain_data", 32'(ram_wdata), 32'h03);
        finish_load();
        wait_empty();

        // Hazard with two entries to the same address; youngest wins
        ld_valid = 1'b1; ld_addr = 15'h0100; ld_exp = 8'hA5;
        st_valid = 1'b1; st_addr = 15'h5678; st_data = 8'h03;
        sample();
        chk("haz2_unrel_ready", 32'(ld_ready), 32'd1);
        advance();
        st_data = 8'h04;
        sample(); advance();
        st_valid = 1'b0; ld_addr = 15'h5678; ld_exp = 8'h04;
        sample();
`ifdef STORE_FWD_EN
        chk("haz2_ld_ready", 32'(ld_ready), 32'd1);
`else
        chk("haz2_ld_ready", 32'(ld_ready), 32'd0);
`endif
        chk("haz2_count", 32'(count), 32'd2);
        chk("haz2_drain_old", 32'(ram_wdata), 32'h03);
        finish_load();
        wait_empty();

        // Full: loads block drains until the buffer fills
        ld_valid = 1'b1; ld_addr = 15'h0100; ld_exp = 8'hA5;
        st_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_addr = 15'h0200 + 15'(i);
            st_data = 8'(i + 1);
            sample(); advance();
        end
        st_addr = 15'h0204; st_data = 8'h05;
        sample();
        chk("full_count", 32'(count), 32'd4);
        chk("full_st_ready", 32'(st_ready), 32'd0);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_forced_drain", 32'({ram_we, ram_addr}), 32'({1'b1, 15'h0200}));
        advance();
        sample();
        chk("full_5th_accept", 32'(st_ready), 32'd1);
        chk("full_after_count", 32'(count), 32'd3);
        advance();
        st_valid = 1'b0; ld_valid = 1'b0;
        wait_empty();

        // Reset mid-queue
        ld_valid = 1'b1; ld_addr = 15'h0100; ld_exp = 8'hA5;
        st_valid = 1'b1; st_addr = 15'h1234;
        for (int i = 0; i < 3; i++) begin
            st_data = 8'(8'h11 * (i + 1));
            sample(); advance();
        end
        st_valid = 1'b0;
        sample();
        chk("mid_count", 32'(count), 32'd3);
        advance();
        ld_valid = 1'b0; rst = 1'b1;
        ld_q.delete(); wr_q.delete();
        sample();
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        chk("mid_rst_rsp_valid", 32'(ld_rsp_valid), 32'd0);
        chk("mid_rst_st_ready", 32'(st_ready), 32'd1);
        advance();
        rst = 1'b0;
        ld_valid = 1'b1; ld_addr = 15'h1234; ld_exp = 8'h56;
        sample();
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
        advance();
        ld_valid = 1'b0;
        sample();
        chk("post_rst_rsp_valid", 32'(ld_rsp_valid), 32'd1);
        advance();
        repeat (2) advance();

        chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
